key_select_input: RTL and testbench

Input-side companion to the LED flow output driver in the selecting machine startup test. It reads four active-low push-buttons, synchronizes and debounces each one, and turns clean presses into single-cycle events. A browse/lock state machine uses those events to select one of NUM_ITEMS items. It outputs the selected index, as binary and as one-hot, so the LED stage can display the selection and downstream logic can act on a confirmed choice.

---
 rtl/key_select_input.sv | 158 +++++++++++++++
 tb/tb_key_select_input.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/key_select_input.sv
// key_select_input: four active-low push-buttons are synchronized and
// debounced, and each clean press becomes a one-cycle event. A browse/lock
// selector uses those events to choose one of NUM_ITEMS items.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   BROWSE  | next/prev move sel_idx; confirm locks the current index
//   LOCKED  | selection held; only cancel is honoured (back to BROWSE)
module key_select_input #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int NUM_ITEMS       = 10
) (
  input  logic                 clk_50M,
  input  logic                 reset_n,
  input  logic [3:0]           key_n,
  output logic [3:0]           key_db,
  output logic [3:0]           sel_idx,
  output logic [NUM_ITEMS-1:0] sel_onehot,
  output logic                 locked,
  output logic [3:0]           confirmed_idx,
  output logic                 confirm_pulse,
  output logic                 cancel_pulse
);

  localparam int             CW       = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0]  CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [3:0]     IDX_LAST = 4'(NUM_ITEMS - 1);

  typedef enum logic {BROWSE = 1'b0, LOCKED = 1'b1} state_t;

  logic [3:0]           sync1_q;
  logic [3:0]           key_s_q;
  logic [CW-1:0]        cnt_q [4];
  logic [CW-1:0]        cnt_d [4];
  logic [3:0]           key_db_q;
  logic [3:0]           key_db_d;
  logic [3:0]           key_db_prev_q;
  logic [3:0]           press_q;

  state_t               state_q;
  logic [3:0]           sel_q;
  logic [3:0]           sel_d;
  logic [NUM_ITEMS-1:0] onehot_q;
  logic [NUM_ITEMS-1:0] onehot_d;
  logic                 locked_q;
  logic [3:0]           conf_idx_q;
  logic                 confirm_pulse_q;
  logic                 cancel_pulse_q;

  // Two-flop synchronizer; idles at "released" so reset does not fake a press.
  always_ff @(posedge clk_50M or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q <= 4'hF;
      key_s_q <= 4'hF;
    end else begin
      sync1_q <= key_n;
      key_s_q <= sync1_q;
    end
  end

  // Debounce: count consecutive mismatching samples, accept on the last one.
  always_comb begin
    key_db_d = key_db_q;
    for (int i = 0; i < 4; i++) begin
      cnt_d[i] = '0;
      if (key_s_q[i] != key_db_q[i]) begin
        if (cnt_q[i] == CNT_LAST) begin
          key_db_d[i] = key_s_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CW'(1);
        end
      end
    end
  end

  // Debounce state plus the press detector (falling edge of the clean level).
  always_ff @(posedge clk_50M or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 4; i++) begin
        cnt_q[i] <= '0;
      end
      key_db_q      <= 4'hF;
      key_db_prev_q <= 4'hF;
      press_q       <= 4'h0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
      key_db_q      <= key_db_d;
      key_db_prev_q <= key_db_q;
      press_q       <= key_db_prev_q & ~key_db_q;
    end
  end

  // Next selection index; confirm wins over next/prev, next+prev cancel out.
  always_comb begin
    sel_d = sel_q;
    if (state_q == BROWSE && !press_q[2]) begin
      if (press_q[0] && !press_q[1]) begin
        sel_d = (sel_q == IDX_LAST) ? 4'd0 : sel_q + 4'd1;
      end else if (press_q[1] && !press_q[0]) begin
        sel_d = (sel_q == 4'd0) ? IDX_LAST : sel_q - 4'd1;
      end
    end
  end

  // One-hot decode of the next index, so it registers alongside sel_idx.
  always_comb begin
    onehot_d = '0;
    for (int i = 0; i < NUM_ITEMS; i++) begin
      onehot_d[i] = (sel_d == 4'(i));
    end
  end

  // Browse/lock FSM with registered outputs and one-cycle strobes.
  always_ff @(posedge clk_50M or negedge reset_n) begin
    if (!reset_n) begin
      state_q         <= BROWSE;
      sel_q           <= 4'd0;
      onehot_q        <= NUM_ITEMS'(1);
      locked_q        <= 1'b0;
      conf_idx_q      <= 4'd0;
      confirm_pulse_q <= 1'b0;
      cancel_pulse_q  <= 1'b0;
    end else begin
      confirm_pulse_q <= 1'b0;
      cancel_pulse_q  <= 1'b0;
      sel_q           <= sel_d;
      onehot_q        <= onehot_d;
      case (state_q)
        BROWSE: begin
          if (press_q[2]) begin
            state_q         <= LOCKED;
            locked_q        <= 1'b1;
            conf_idx_q      <= sel_q;
            confirm_pulse_q <= 1'b1;
          end
        end
        LOCKED: begin
          if (press_q[3]) begin
            state_q        <= BROWSE;
            locked_q       <= 1'b0;
            cancel_pulse_q <= 1'b1;
          end
        end
      endcase
    end
  end

  assign key_db        = key_db_q;
  assign sel_idx       = sel_q;
  assign sel_onehot    = onehot_q;
  assign locked        = locked_q;
  assign confirmed_idx = conf_idx_q;
  assign confirm_pulse = confirm_pulse_q;
  assign cancel_pulse  = cancel_pulse_q;

endmodule

// File: tb/tb_key_select_input.sv
// Bench for key_select_input: directed scenarios plus random key operations,
// checked against an operation-level model of the selector.
module tb_key_select_input;

  localparam int N     = 4;
  localparam int ITEMS = 10;

  logic             clk_50M;
  logic             reset_n;
  logic [3:0]       key_n;
  logic [3:0]       key_db;
  logic [3:0]       sel_idx;
  logic [ITEMS-1:0] sel_onehot;
  logic             locked;
  logic [3:0]       confirmed_idx;
  logic             confirm_pulse;
  logic             cancel_pulse;

  int checks = 0;
  int errors = 0;
  int conf_cnt = 0;
  int canc_cnt = 0;

  int m_sel = 0;
  int m_locked = 0;
  int m_conf = 0;

  key_select_input #(.DEBOUNCE_CYCLES(N), .NUM_ITEMS(ITEMS)) dut (
    .clk_50M       (clk_50M),
    .reset_n       (reset_n),
    .key_n         (key_n),
    .key_db        (key_db),
    .sel_idx       (sel_idx),
    .sel_onehot    (sel_onehot),
    .locked        (locked),
    .confirmed_idx (confirmed_idx),
    .confirm_pulse (confirm_pulse),
    .cancel_pulse  (cancel_pulse)
  );

  initial clk_50M = 1'b0;
  always #5 clk_50M = ~clk_50M;

  always @(negedge clk_50M) begin
    if (confirm_pulse) conf_cnt++;
    if (cancel_pulse) canc_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_state(input string tag);
    logic [31:0] oh;
    oh = 32'd1 << m_sel;
    chk({tag, ".sel"}, 32'(sel_idx), 32'(m_sel));
    chk({tag, ".onehot"}, 32'(sel_onehot), oh);
    chk({tag, ".locked"}, 32'(locked), 32'(m_locked));
    chk({tag, ".conf_idx"}, 32'(confirmed_idx), 32'(m_conf));
    chk({tag, ".key_db"}, 32'(key_db), 32'hF);
  endtask

  // Press the keys in mask together, hold, release, then compare with the model.
  task automatic do_op(input logic [3:0] keys, input string tag);
    int exp_conf;
    int exp_canc;
    logic [3:0] kdb;
    exp_conf = 0;
    exp_canc = 0;
    if (m_locked == 0) begin
      if (keys[2]) begin
        m_locked = 1;
        m_conf = m_sel;
        exp_conf = 1;
      end else if (keys[0] && !keys[1]) begin
        m_sel = (m_sel + 1) % ITEMS;
      end else if (keys[1] && !keys[0]) begin
        m_sel = (m_sel + ITEMS - 1) % ITEMS;
      end
    end else if (keys[3]) begin
      m_locked = 0;
      exp_canc = 1;
    end
    @(negedge clk_50M);
    #2;
    conf_cnt = 0;
    canc_cnt = 0;
    key_n = ~keys;
    repeat (14) @(negedge clk_50M);
    kdb = ~keys;
    chk({tag, ".key_db_held"}, 32'(key_db), 32'(kdb));
    #2;
    key_n = 4'hF;
    repeat (14) @(negedge clk_50M);
    check_state(tag);
    chk({tag, ".confirm_pulses"}, 32'(conf_cnt), 32'(exp_conf));
    chk({tag, ".cancel_pulses"}, 32'(canc_cnt), 32'(exp_canc));
  endtask

  initial begin
    #1000000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    int lat;
    int start;
    logic [3:0] keys;
    reset_n = 1'b0;
    key_n   = 4'hF;
    repeat (3) @(negedge clk_50M);
    chk("rst.key_db", 32'(key_db), 32'hF);
    chk("rst.onehot", 32'(sel_onehot), 32'h1);
    #2 reset_n = 1'b1;
    repeat (2) @(negedge clk_50M);
    check_state("after_reset");
    chk("rst.pulses", 32'({confirm_pulse, cancel_pulse}), 32'h0);

    // Reset while next is mid-debounce, key kept held through release.
    #2 key_n = 4'hE;
    repeat (3) @(negedge clk_50M);
    #2 reset_n = 1'b0;
    #1;
    chk("midrst.key_db", 32'(key_db), 32'hF);
    chk("midrst.sel", 32'(sel_idx), 32'h0);
    chk("midrst.onehot", 32'(sel_onehot), 32'h1);
    repeat (2) @(negedge clk_50M);
    #2 reset_n = 1'b1;
    repeat (20) @(negedge clk_50M);
    m_sel = 1;
    chk("held_through_reset.sel", 32'(sel_idx), 32'(m_sel));
    #2 key_n = 4'hF;
    repeat (14) @(negedge clk_50M);
    check_state("held_release");

    // Short glitch: 3 samples low must not register.
    #2 key_n = 4'hE;
    repeat (3) @(negedge clk_50M);
    #2 key_n = 4'hF;
    repeat (12) @(negedge clk_50M);
    check_state("glitch3");

    // Latency from pin fall to sel_idx change.
    start = sel_idx;
    lat = 0;
    #2 key_n = 4'hE;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk_50M);
      #1;
      if (sel_idx != 4'(start)) begin
        lat = k + 1;
        break;
      end
    end
    chk("latency_edges", 32'(lat), 32'(N + 4));
    @(negedge clk_50M);
    repeat (16) @(negedge clk_50M);
    #2 key_n = 4'hF;
    repeat (14) @(negedge clk_50M);
    m_sel = (m_sel + 1) % ITEMS;
    check_state("held_20");

    // Random sub-threshold glitches on random key sets.
    for (int g = 0; g < 8; g++) begin
      #2 key_n = ~4'($urandom_range(1, 15));
      conf_cnt = 0;
      canc_cnt = 0;
      repeat ($urandom_range(1, N - 1)) @(negedge clk_50M);
      #2 key_n = 4'hF;
      repeat (N + 6) @(negedge clk_50M);
      check_state("rand_glitch");
      chk("rand_glitch.pulses", 32'(conf_cnt + canc_cnt), 32'h0);
    end

    // Wrap forward from current position back to 0, then once more around.
    while (m_sel != 0) do_op(4'b0001, "to_zero");
    for (int i = 0; i < ITEMS; i++) do_op(4'b0001, "wrap_next");
    do_op(4'b0010, "wrap_prev");
    chk("onehot_at_9", 32'(sel_onehot), 32'h200);

    do_op(4'b0011, "next_and_prev");
    while (m_sel != 5) do_op(4'b0001, "to_five");
    do_op(4'b0101, "confirm_and_next");
    chk("confirmed_is_5", 32'(confirmed_idx), 32'd5);
    do_op(4'b0001, "locked_next");
    do_op(4'b0010, "locked_prev");
    do_op(4'b0100, "locked_confirm");
    do_op(4'b1000, "cancel");
    do_op(4'b1000, "cancel_browse");

    for (int r = 0; r < 40; r++) begin
      if ($urandom_range(0, 1) == 1) keys = 4'd1 << $urandom_range(0, 3);
      else keys = 4'($urandom_range(1, 15));
      do_op(keys, "random_op");
    end

    // Reset while locked on 7.
    if (m_locked != 0) do_op(4'b1000, "unlock");
    while (m_sel != 7) do_op(4'b0001, "to_seven");
    do_op(4'b0100, "confirm_seven");
    chk("confirmed_is_7", 32'(confirmed_idx), 32'd7);
    @(negedge clk_50M);
    #2 reset_n = 1'b0;
    #1;
    chk("lockrst.locked", 32'(locked), 32'h0);
    chk("lockrst.conf_idx", 32'(confirmed_idx), 32'h0);
    chk("lockrst.sel", 32'(sel_idx), 32'h0);
    @(negedge clk_50M);
    #2 reset_n = 1'b1;
    m_sel = 0;
    m_locked = 0;
    m_conf = 0;
    repeat (4) @(negedge clk_50M);
    check_state("after_lock_reset");
    do_op(4'b0001, "post_reset_next");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
